// File: rtl/conv_pool_engine.sv
// conv_pool_engine: streaming 3x3 conv, ReLU, requantise and 2x2 max-pool over a memory-mapped 8-bit image
module conv_pool_engine #(
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  reg_req_i,
  input  logic                  reg_we_i,
  input  logic [ADDR_WIDTH-1:0] reg_addr_i,
  input  logic [31:0]           reg_wdata_i,
  output logic                  reg_gnt_o,
  output logic                  reg_rvalid_o,
  output logic [31:0]           reg_rdata_o,
  output logic                  reg_err_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  irq_o
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int PB = 2 ** (CW - 1);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, COMPUTE, WR_REQ, WR_WAIT, DONE} state_t;
  state_t state;
  logic busy, done, last_q;
  logic [ADDR_WIDTH-1:0] in_base, out_base, rd_ptr, wr_ptr;
  logic [4:0] shift;
  logic signed [DATA_WIDTH-1:0] w [9];
  logic [DATA_WIDTH-1:0] win [9];
  logic [DATA_WIDTH-1:0] lb0 [IMG_W];
  logic [DATA_WIDTH-1:0] lb1 [IMG_W];
  logic [DATA_WIDTH-1:0] pool_buf [PB];
  logic [DATA_WIDTH-1:0] pair_q, pool_q, q, pair_max, pool_max;
  logic [CW-1:0] c;
  logic [RW-1:0] r;
  logic [CW-2:0] pidx;
  logic signed [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] sh;
  logic [7:0] a;
  logic [3:0] wi;
  logic [31:0] rdata_c;
  logic is_w, mapped, locked, err_c, wr_ok, start, valid, last_col, last_row, last, emit;
  logic unused_addr;
  assign unused_addr = ^reg_addr_i[ADDR_WIDTH-1:8];
  assign a = reg_addr_i[7:0];
  assign wi = 4'(a[6:2] - 5'd8);
  assign is_w = a >= 8'h20 && a <= 8'h40 && a[1:0] == 2'b00;
  assign mapped = a == 8'h00 || a == 8'h04 || a == 8'h08 || a == 8'h0C || a == 8'h10 || is_w;
  assign locked = busy && (a == 8'h08 || a == 8'h0C || a == 8'h10 || is_w || (a == 8'h00 && reg_wdata_i[0]));
  assign err_c = !mapped || (reg_we_i && locked);
  assign wr_ok = reg_req_i && reg_we_i && !err_c;
  assign start = wr_ok && a == 8'h00 && reg_wdata_i[0];
  assign rdata_c = a == 8'h04 ? {30'h0, done, busy}
                 : a == 8'h08 ? 32'(in_base)
                 : a == 8'h0C ? 32'(out_base)
                 : a == 8'h10 ? {27'h0, shift}
                 : is_w ? {{(32-DATA_WIDTH){w[wi][DATA_WIDTH-1]}}, w[wi]} : '0;
  assign reg_gnt_o = reg_req_i;
  always_comb begin
    acc = '0;
    for (int k = 0; k < 9; k++)
      acc = acc + ACC_WIDTH'($signed({1'b0, win[k]})) * ACC_WIDTH'(w[k]);
  end
  assign sh = acc[ACC_WIDTH-1] ? '0 : $unsigned(acc) >> shift;
  assign q = |sh[ACC_WIDTH-1:DATA_WIDTH] ? '1 : sh[DATA_WIDTH-1:0];
  assign pidx = c[CW-1:1] - (CW-1)'(1);
  assign pair_max = pair_q > q ? pair_q : q;
  assign pool_max = pool_buf[pidx] > pair_max ? pool_buf[pidx] : pair_max;
  assign valid = r >= RW'(2) && c >= CW'(2);
  assign emit = valid && r[0] && c[0];
  assign last_col = c == CW'(IMG_W - 1);
  assign last_row = r == RW'(IMG_H - 1);
  assign last = last_col && last_row;
  assign mem_req_o = state == RD_REQ || state == WR_REQ;
  assign mem_we_o = state == WR_REQ;
  assign mem_addr_o = state == WR_REQ ? wr_ptr : state == RD_REQ ? rd_ptr : '0;
  assign mem_wdata_o = pool_q;
  assign irq_o = state == DONE;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      last_q <= 1'b0;
      reg_rvalid_o <= 1'b0;
      reg_rdata_o <= '0;
      reg_err_o <= 1'b0;
      in_base <= '0;
      out_base <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      shift <= '0;
      pair_q <= '0;
      pool_q <= '0;
      c <= '0;
      r <= '0;
      for (int i = 0; i < 9; i++) begin
        w[i] <= '0;
        win[i] <= '0;
      end
      for (int i = 0; i < IMG_W; i++) begin
        lb0[i] <= '0;
        lb1[i] <= '0;
      end
      for (int i = 0; i < PB; i++) pool_buf[i] <= '0;
    end else begin
      reg_rvalid_o <= reg_req_i;
      reg_rdata_o <= reg_req_i && mapped ? rdata_c : '0;
      reg_err_o <= reg_req_i && err_c;
      if (wr_ok && a == 8'h08) in_base <= reg_wdata_i[ADDR_WIDTH-1:0];
      if (wr_ok && a == 8'h0C) out_base <= reg_wdata_i[ADDR_WIDTH-1:0];
      if (wr_ok && a == 8'h10) shift <= reg_wdata_i[4:0];
      if (wr_ok && is_w) w[wi] <= reg_wdata_i[DATA_WIDTH-1:0];
      if (wr_ok && a == 8'h04 && reg_wdata_i[1]) done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= RD_REQ;
          busy <= 1'b1;
          done <= 1'b0;
          rd_ptr <= in_base;
          wr_ptr <= out_base;
        end
        RD_REQ: if (mem_gnt_i) begin
          state <= RD_WAIT;
          rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
        end
        RD_WAIT: if (mem_rvalid_i) begin
          for (int d = 0; d < 3; d++) begin
            win[3*d] <= win[3*d+1];
            win[3*d+1] <= win[3*d+2];
          end
          win[2] <= lb1[c];
          win[5] <= lb0[c];
          win[8] <= mem_rdata_i;
          lb1[c] <= lb0[c];
          lb0[c] <= mem_rdata_i;
          state <= COMPUTE;
        end
        COMPUTE: begin
          if (valid && !c[0]) pair_q <= q;
          if (valid && c[0] && !r[0]) pool_buf[pidx] <= pair_max;
          if (emit) pool_q <= pool_max;
          last_q <= last;
          c <= last_col ? '0 : c + CW'(1);
          if (last_col) r <= last_row ? '0 : r + RW'(1);
          state <= emit ? WR_REQ : last ? DONE : RD_REQ;
        end
        WR_REQ: if (mem_gnt_i) begin
          state <= WR_WAIT;
          wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
        end
        WR_WAIT: if (mem_rvalid_i) state <= last_q ? DONE : RD_REQ;
        DONE: begin
          busy <= 1'b0;
          done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
